// File: rtl/aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mode_ctrl
//  Description : ECB/CBC mode controller wrapped around an external
//                combinational AES ECB core. Accepts 128-bit blocks on a
//                valid/ready handshake, registers the (optionally chained)
//                plaintext and key towards the core, waits CORE_LAT cycles
//                for the core to settle, then presents the ciphertext on a
//                valid/ready output handshake. The CBC chain is restored
//                from the stored IV after the last block of each message.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_mode_ctrl #(
   parameter int unsigned CORE_LAT = 1        // core settle cycles, 1..255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mode,                // 0 = ECB, 1 = CBC
   input  logic [127:0]  key,
   input  logic [127:0]  iv,
   input  logic          iv_load,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_data,
   output logic          out_last,
   output logic [127:0]  core_din,
   output logic [127:0]  core_key,
   input  logic [127:0]  core_dout,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Counter preload: a value of N-1 gives exactly N WAIT cycles.
   localparam logic [7:0] C_CNT_INIT = 8'(CORE_LAT - 1);

   state_t         state_q,    state_d;
   logic [7:0]     cnt_q,      cnt_d;
   logic [127:0]   core_din_q, core_din_d;
   logic [127:0]   core_key_q, core_key_d;
   logic           mode_q,     mode_d;
   logic           last_q,     last_d;
   logic [127:0]   out_data_q, out_data_d;
   logic           out_last_q, out_last_d;
   logic [127:0]   chain_q,    chain_d;
   logic [127:0]   iv_reg_q,   iv_reg_d;

   // Next-state and datapath updates; every register holds unless its state acts.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      core_din_d = core_din_q;
      core_key_d = core_key_q;
      mode_d     = mode_q;
      last_d     = last_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      chain_d    = chain_q;
      iv_reg_d   = iv_reg_q;

      case (state_q)
         IDLE: begin
            // An IV load takes effect after this edge; a block accepted on
            // the same edge still chains with the value held before it.
            if (iv_load) begin
               iv_reg_d = iv;
               chain_d  = iv;
            end
            if (in_valid) begin
               core_din_d = mode ? (in_data ^ chain_q) : in_data;
               core_key_d = key;
               mode_d     = mode;
               last_d     = in_last;
               cnt_d      = C_CNT_INIT;
               state_d    = WAIT;
            end
         end

         WAIT: begin
            if (cnt_q == 8'd0) begin
               out_data_d = core_dout;
               out_last_d = last_q;
               if (mode_q) begin
                  chain_d = core_dout;
               end
               state_d = OUT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         OUT: begin
            if (out_ready) begin
               // End of message: next message restarts from the stored IV.
               if (out_last_q) begin
                  chain_d = iv_reg_q;
               end
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         core_din_q <= 128'h0;
         core_key_q <= 128'h0;
         mode_q     <= 1'b0;
         last_q     <= 1'b0;
         out_data_q <= 128'h0;
         out_last_q <= 1'b0;
         chain_q    <= 128'h0;
         iv_reg_q   <= 128'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         core_din_q <= core_din_d;
         core_key_q <= core_key_d;
         mode_q     <= mode_d;
         last_q     <= last_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         chain_q    <= chain_d;
         iv_reg_q   <= iv_reg_d;
      end
   end

   // Handshake and status outputs decode directly from the state register.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == OUT);
      busy      = (state_q != IDLE);
   end

   assign out_data = out_data_q;
   assign out_last = out_last_q;
   assign core_din = core_din_q;
   assign core_key = core_key_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_mode_ctrl
//  Description : Self-checking bench for aes_mode_ctrl. A lookup-based model
//                of the AES core returns the SP800-38A reference ciphertexts
//                for the vector inputs and a simple keyed mix otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_mode_ctrl;

   localparam logic [127:0] K      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_ECB  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] C_CBC1 = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] C_CBC2 = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] JUNK   = 128'hdeadbeef_cafef00d_01234567_89abcdef;

   // Core stand-in: exact AES results for the reference inputs.
   function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
      if (k == K && d == P1)                 return C_ECB;
      else if (k == K && d == (P1 ^ IV))     return C_CBC1;
      else if (k == K && d == (P2 ^ C_CBC1)) return C_CBC2;
      else return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mode = 1'b0;
   logic [127:0]  key = '0;
   logic [127:0]  iv = '0;
   logic          iv_load = 1'b0;
   logic          in_valid = 1'b0;
   logic [127:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;

   logic          in_ready, out_valid, out_last, busy;
   logic [127:0]  out_data, core_din, core_key, core_dout;

   logic          in_ready_1, out_valid_1, out_last_1, busy_1;
   logic [127:0]  out_data_1, core_din_1, core_key_1, core_dout_1;
   logic          in_ready_255, out_valid_255, out_last_255, busy_255;
   logic [127:0]  out_data_255, core_din_255, core_key_255, core_dout_255;

   assign core_dout     = core_fn(core_din, core_key);
   assign core_dout_1   = core_fn(core_din_1, core_key_1);
   assign core_dout_255 = core_fn(core_din_255, core_key_255);

   always #5 clk = ~clk;

   aes_mode_ctrl #(.CORE_LAT(4)) dut (
      .clk(clk), .rst(rst), .mode(mode), .key(key), .iv(iv), .iv_load(iv_load),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .core_din(core_din), .core_key(core_key), .core_dout(core_dout), .busy(busy)
   );

   aes_mode_ctrl #(.CORE_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .mode(mode), .key(key), .iv(iv), .iv_load(iv_load),
      .in_valid(in_valid), .in_ready(in_ready_1), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_1), .out_ready(1'b1), .out_data(out_data_1), .out_last(out_last_1),
      .core_din(core_din_1), .core_key(core_key_1), .core_dout(core_dout_1), .busy(busy_1)
   );

   aes_mode_ctrl #(.CORE_LAT(255)) u_lat255 (
      .clk(clk), .rst(rst), .mode(mode), .key(key), .iv(iv), .iv_load(iv_load),
      .in_valid(in_valid), .in_ready(in_ready_255), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_255), .out_ready(1'b1), .out_data(out_data_255), .out_last(out_last_255),
      .core_din(core_din_255), .core_key(core_key_255), .core_dout(core_dout_255), .busy(busy_255)
   );

   typedef struct packed {
      logic          last;
      logic [127:0]  data;
   } exp_t;

   exp_t          sb_q[$];
   int            checks = 0;
   int            failures = 0;
   logic [127:0]  m_chain = '0;
   logic [127:0]  m_iv = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one block, optionally with a simultaneous iv_load, and push its expected output.
   task automatic send(input logic [127:0] d, input logic lst, input logic md,
                       input logic ivl, input logic [127:0] ivv);
      logic [127:0] din;
      logic [127:0] ex;
      int n;
      n        = 0;
      in_data  = d;
      in_last  = lst;
      mode     = md;
      key      = K;
      in_valid = 1'b1;
      if (ivl) begin
         iv      = ivv;
         iv_load = 1'b1;
      end
      while (!in_ready && n < 400) begin
         tick();
         n++;
      end
      check("accept_ready", {127'd0, in_ready}, 128'd1);
      din = md ? (d ^ m_chain) : d;
      ex  = core_fn(din, K);
      tick();
      in_valid = 1'b0;
      iv_load  = 1'b0;
      if (ivl) begin
         m_iv    = ivv;
         m_chain = ivv;
      end
      if (md)  m_chain = ex;
      if (lst) m_chain = m_iv;
      sb_q.push_back({lst, ex});
   endtask

   // Wait for the output, check latency/data/last, complete the handshake.
   task automatic recv(input string tag, input int explat);
      int lat;
      exp_t e;
      lat = 0;
      while (!out_valid && lat < 400) begin
         tick();
         lat++;
      end
      check({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
      if (explat > 0) check({tag, "_latency"}, 128'(lat), 128'(explat));
      check({tag, "_sb_nonempty"}, 128'(sb_q.size() > 0), 128'd1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      check({tag, "_data"}, out_data, e.data);
      check({tag, "_last"}, {127'd0, out_last}, {127'd0, e.last});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_after"}, {127'd0, in_ready}, 128'd1);
      check({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
   endtask

   initial begin
      int lat1, lat4, lat255;
      logic [127:0] d1, d4, d255;
      int n;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", {127'd0, in_ready}, 128'd1);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_out_data", out_data, 128'h0);
      check("rst_core_din", core_din, 128'h0);
      check("rst_core_key", core_key, 128'h0);

      // ECB reference vector
      send(P1, 1'b1, 1'b0, 1'b0, '0);
      recv("ecb", 4);
      check("ecb_const", core_fn(P1, K), C_ECB);

      // CBC two-block message after an IV load
      iv = IV; iv_load = 1'b1; tick(); iv_load = 1'b0;
      m_iv = IV; m_chain = IV;
      send(P1, 1'b0, 1'b1, 1'b0, '0);
      recv("cbc1", 4);
      send(P2, 1'b1, 1'b1, 1'b0, '0);
      recv("cbc2", 4);

      // Same message again: chain must be restored from the stored IV
      send(P1, 1'b0, 1'b1, 1'b0, '0);
      recv("restore1", 4);
      send(P2, 1'b1, 1'b1, 1'b0, '0);
      recv("restore2", 4);

      // Backpressure: hold out_ready low for 10 cycles in OUT
      send(P1, 1'b1, 1'b0, 1'b0, '0);
      n = 0;
      while (!out_valid && n < 400) begin tick(); n++; end
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", {127'd0, out_valid}, 128'd1);
         check("bp_data", out_data, C_ECB);
         check("bp_in_ready", {127'd0, in_ready}, 128'd0);
         check("bp_busy", {127'd0, busy}, 128'd1);
         tick();
      end
      recv("bp", 0);

      // iv_load pulsed during WAIT must be ignored
      send(P1, 1'b0, 1'b1, 1'b0, '0);
      check("ivw_busy", {127'd0, busy}, 128'd1);
      iv = JUNK; iv_load = 1'b1; tick(); iv_load = 1'b0;
      recv("ivwait1", 3);
      send(P2, 1'b1, 1'b1, 1'b0, '0);
      recv("ivwait2", 4);

      // iv_load together with accept: block uses old chain, then chain = new IV
      send(P1, 1'b1, 1'b1, 1'b1, JUNK);
      recv("ivacc1", 4);
      send(P2, 1'b1, 1'b1, 1'b0, '0);
      recv("ivacc2", 4);

      // Reset during WAIT
      send(P2, 1'b0, 1'b1, 1'b0, '0);
      tick();
      check("mid_busy_pre", {127'd0, busy}, 128'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_busy", {127'd0, busy}, 128'd0);
      check("mid_out_valid", {127'd0, out_valid}, 128'd0);
      check("mid_in_ready", {127'd0, in_ready}, 128'd1);
      check("mid_chain", dut.chain_q, 128'h0);
      check("mid_iv_reg", dut.iv_reg_q, 128'h0);
      check("mid_core_din", core_din, 128'h0);
      sb_q.delete();
      m_chain = '0;
      m_iv = '0;
      send(P1, 1'b1, 1'b0, 1'b0, '0);
      recv("post_rst_ecb", 4);

      // Latency sweep over CORE_LAT = 1, 4, 255
      rst = 1'b1; tick(); rst = 1'b0;
      in_data = P1; in_last = 1'b1; mode = 1'b0; key = K; in_valid = 1'b1;
      check("sw_ready1", {127'd0, in_ready_1}, 128'd1);
      check("sw_ready255", {127'd0, in_ready_255}, 128'd1);
      tick();
      in_valid = 1'b0;
      lat1 = -1; lat4 = -1; lat255 = -1;
      d1 = '0; d4 = '0; d255 = '0;
      for (int c = 1; c <= 300; c++) begin
         tick();
         if (lat1 < 0 && out_valid_1)     begin lat1 = c;   d1 = out_data_1;     end
         if (lat4 < 0 && out_valid)       begin lat4 = c;   d4 = out_data;       end
         if (lat255 < 0 && out_valid_255) begin lat255 = c; d255 = out_data_255; end
      end
      check("sw_lat1", 128'(lat1), 128'd1);
      check("sw_lat4", 128'(lat4), 128'd4);
      check("sw_lat255", 128'(lat255), 128'd255);
      check("sw_data1", d1, C_ECB);
      check("sw_data4", d4, C_ECB);
      check("sw_data255", d255, C_ECB);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("sw_done", {127'd0, in_ready}, 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
